fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/cpu_common.sv | 13 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_common.sv
// Shared CPU front-end types: fetch request reasons and instruction width.
package cpu_common;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    IF_PREFETCH   = 2'd0,
    IF_PREDICT    = 2'd1,
    IF_MISPREDICT = 2'd2,
    IF_TRAP       = 2'd3
  } if_reason_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry response buffer with synchronous reset and single-cycle flush.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       cnt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok    = push && (cnt != 2'd2);
  assign pop_ok     = pop && (cnt != 2'd0);
  assign head_valid = (cnt != 2'd0);
  assign head_data  = mem[rd_ptr];
  assign count      = cnt;

  // Pointers and occupancy; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push_ok) - 2'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding icache requests, redirect
// handling with stale-response kill, and a 2-entry decode-side buffer.
module fetch_sequencer
  import cpu_common::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  if_reason_t         redirect_reason,
  output logic               ic_req_valid,
  output logic [XLEN-1:0]    ic_req_pc,
  output if_reason_t         ic_req_reason,
  input  logic               ic_resp_valid,
  input  logic [XLEN-1:0]    ic_resp_pc,
  input  logic [INSTR_W-1:0] ic_resp_instr,
  input  logic               ic_resp_exception,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_exception
);

  localparam int unsigned ENTRY_W = XLEN + INSTR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [XLEN-1:0]    next_pc_q;
  logic [XLEN-1:0]    next_pc_nxt;
  logic [XLEN-1:0]    pend_pc_q;
  logic [XLEN-1:0]    pend_pc_nxt;
  if_reason_t         pend_reason_q;
  if_reason_t         pend_reason_nxt;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               head_valid;
  logic [1:0]         fifo_count;
  logic [1:0]         count_after_pop;
  logic               room_no_push;
  logic               room_with_push;
  logic [XLEN-1:0]    seq_pc;

  // Sequential PC after the responding instruction (16-bit vs 32-bit encoding).
  assign seq_pc = (ic_resp_instr[1:0] != 2'b11) ? ic_resp_pc + XLEN'(2)
                                                : ic_resp_pc + XLEN'(4);

  assign push_data = {ic_resp_pc, ic_resp_instr, ic_resp_exception};
  assign {out_pc, out_instr, out_exception} = head_data;
  assign out_valid = head_valid && !redirect_valid && !rst;
  assign pop       = out_valid && out_ready;

  // A fetch may issue only if the buffer stays below two entries after this cycle.
  assign count_after_pop = fifo_count - 2'(pop);
  assign room_no_push    = (count_after_pop < 2'd2);
  assign room_with_push  = (count_after_pop == 2'd0);

  fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      next_pc_q     <= '0;
      pend_pc_q     <= '0;
      pend_reason_q <= IF_PREFETCH;
    end else begin
      state         <= state_nxt;
      next_pc_q     <= next_pc_nxt;
      pend_pc_q     <= pend_pc_nxt;
      pend_reason_q <= pend_reason_nxt;
    end
  end

  // Next-state, request issue and buffer push.
  always_comb begin
    state_nxt       = state;
    next_pc_nxt     = next_pc_q;
    pend_pc_nxt     = pend_pc_q;
    pend_reason_nxt = pend_reason_q;
    ic_req_valid    = 1'b0;
    ic_req_pc       = redirect_pc;
    ic_req_reason   = redirect_reason;
    push            = 1'b0;

    case (state)
      IDLE: begin
        if (redirect_valid) begin
          ic_req_valid = 1'b1;
          state_nxt    = WAIT;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          ic_req_valid = 1'b1;
          state_nxt    = WAIT;
        end else if (room_no_push) begin
          ic_req_valid  = 1'b1;
          ic_req_pc     = next_pc_q;
          ic_req_reason = IF_PREFETCH;
          state_nxt     = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          if (ic_resp_valid) begin
            ic_req_valid = 1'b1;
          end else begin
            pend_pc_nxt     = redirect_pc;
            pend_reason_nxt = redirect_reason;
            state_nxt       = WAIT_KILL;
          end
        end else if (ic_resp_valid) begin
          push = 1'b1;
          if (ic_resp_exception) begin
            state_nxt = IDLE;
          end else if (room_with_push) begin
            ic_req_valid  = 1'b1;
            ic_req_pc     = seq_pc;
            ic_req_reason = IF_PREFETCH;
          end else begin
            next_pc_nxt = seq_pc;
            state_nxt   = HOLD;
          end
        end
      end

      WAIT_KILL: begin
        if (ic_resp_valid) begin
          ic_req_valid = 1'b1;
          if (!redirect_valid) begin
            ic_req_pc     = pend_pc_q;
            ic_req_reason = pend_reason_q;
          end
          state_nxt = WAIT;
        end else if (redirect_valid) begin
          pend_pc_nxt     = redirect_pc;
          pend_reason_nxt = redirect_reason;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      ic_req_valid = 1'b0;
      push         = 1'b0;
    end
  end

endmodule
